// File: rtl/mem_access_stage_pkg.sv
// Shared encodings and sizing for the memory-access pipeline stage.
package mem_stage_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] CTRL_NOP   = 2'b00;
    localparam logic [1:0] CTRL_ALU   = 2'b01;
    localparam logic [1:0] CTRL_LOAD  = 2'b10;
    localparam logic [1:0] CTRL_STORE = 2'b11;

    localparam logic [CNT_W-1:0] TIMEOUT = 4'd15;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Loads and stores both carry a set upper control bit.
    function automatic logic is_mem_op(input logic [1:0] ctrl);
        return ctrl[1];
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus bundle: the stage is the master, the memory the slave.
interface mem_access_stage_if;
    import mem_stage_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mem_access_stage_timeout_counter.sv
// Wait-cycle counter for an outstanding memory access; flags the cycle whose
// increment would reach TIMEOUT.
module mem_timeout_counter
    import mem_stage_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && !clear && (count_q == TIMEOUT - 4'd1);

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: passes ALU results straight to writeback and runs
// loads/stores against a ready-handshaked data memory with a wait timeout.
module mem_access_stage
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [1:0]        control_signals_in,
    input  logic [DATA_W-1:0] value_in,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [REG_W-1:0]  reg_to_be_written_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [REG_W-1:0]  wb_reg,
    output logic [DATA_W-1:0] wb_value,
    output logic              mem_err
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [REG_W-1:0]  reg_q, reg_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_en_q, wb_en_d;
    logic [REG_W-1:0]  wb_reg_q, wb_reg_d;
    logic [DATA_W-1:0] wb_value_q, wb_value_d;
    logic              err_q, err_d;

    logic accept_mem;
    logic wait_cycle;
    logic expired;

    assign accept_mem = (state_q == IDLE) && in_valid && is_mem_op(control_signals_in);
    assign wait_cycle = (state_q == BUSY) && !mem_ready;

    mem_timeout_counter u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept_mem),
        .enable  (wait_cycle),
        .expired (expired)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        reg_d      = reg_q;
        wb_valid_d = 1'b0;
        wb_en_d    = 1'b0;
        wb_reg_d   = wb_reg_q;
        wb_value_d = wb_value_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_mem_op(control_signals_in)) begin
                        state_d = BUSY;
                        we_d    = (control_signals_in == CTRL_STORE);
                        addr_d  = address_in;
                        wdata_d = value_in;
                        reg_d   = reg_to_be_written_in;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_en_d    = (control_signals_in == CTRL_ALU);
                        wb_reg_d   = reg_to_be_written_in;
                        wb_value_d = value_in;
                    end
                end
            end
            BUSY: begin
                // Completion takes precedence over a timeout in the same cycle.
                if (mem_ready) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_en_d    = !we_q;
                    wb_reg_d   = reg_q;
                    if (!we_q) begin
                        wb_value_d = mem_rdata;
                    end
                end else if (expired) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_reg_d   = reg_q;
                    err_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            reg_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_reg_q   <= '0;
            wb_value_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            reg_q      <= reg_d;
            wb_valid_q <= wb_valid_d;
            wb_en_q    <= wb_en_d;
            wb_reg_q   <= wb_reg_d;
            wb_value_q <= wb_value_d;
            err_q      <= err_d;
        end
    end

    assign stall     = (state_q == BUSY);
    assign mem_req   = (state_q == BUSY);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_en     = wb_en_q;
    assign wb_reg    = wb_reg_q;
    assign wb_value  = wb_value_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, loads, stores,
// timeout, reset and back-to-back behaviour.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  ctrl;
    logic [63:0] value_in;
    logic [7:0]  address_in;
    logic [3:0]  reg_in;
    logic        stall;
    logic        wb_valid;
    logic        wb_en;
    logic [3:0]  wb_reg;
    logic [63:0] wb_value;
    logic        mem_err;

    int checks = 0;
    int passed = 0;

    mem_access_stage_if bus ();

    mem_access_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_valid             (in_valid),
        .control_signals_in   (ctrl),
        .value_in             (value_in),
        .address_in           (address_in),
        .reg_to_be_written_in (reg_in),
        .stall                (stall),
        .mem_req              (bus.mem_req),
        .mem_we               (bus.mem_we),
        .mem_addr             (bus.mem_addr),
        .mem_wdata            (bus.mem_wdata),
        .mem_ready            (bus.mem_ready),
        .mem_rdata            (bus.mem_rdata),
        .wb_valid             (wb_valid),
        .wb_en                (wb_en),
        .wb_reg               (wb_reg),
        .wb_value             (wb_value),
        .mem_err              (mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] c, input logic [63:0] v,
                         input logic [7:0] a, input logic [3:0] r);
        in_valid   = 1'b1;
        ctrl       = c;
        value_in   = v;
        address_in = a;
        reg_in     = r;
    endtask

    task automatic test_reset();
        logic [145:0] got;
        rst = 1'b1;
        step();
        step();
        got = {stall, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
               wb_valid, wb_en, wb_reg, wb_value, mem_err};
        checks++;
        if (got !== '0) $display("FAIL reset_outputs: got %h expected 0", got);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_alu();
        issue(2'b01, 64'h5, 8'h00, 4'd3);
        step();
        in_valid = 1'b0;
        checks++;
        if ({wb_valid, wb_en, wb_reg, wb_value, stall} !== {1'b1, 1'b1, 4'd3, 64'h5, 1'b0})
            $display("FAIL alu_wb: got v=%b en=%b reg=%h val=%h stall=%b expected 1 1 3 5 0",
                     wb_valid, wb_en, wb_reg, wb_value, stall);
        else passed++;
        step();
        checks++;
        if ({wb_valid, wb_reg, wb_value} !== {1'b0, 4'd3, 64'h5})
            $display("FAIL idle_no_wb_hold: got v=%b reg=%h val=%h expected 0 3 5",
                     wb_valid, wb_reg, wb_value);
        else passed++;
        issue(2'b00, 64'h9, 8'h00, 4'd7);
        step();
        in_valid = 1'b0;
        checks++;
        if ({wb_valid, wb_en, wb_reg, wb_value} !== {1'b1, 1'b0, 4'd7, 64'h9})
            $display("FAIL bubble_wb: got v=%b en=%b reg=%h val=%h expected 1 0 7 9",
                     wb_valid, wb_en, wb_reg, wb_value);
        else passed++;
    endtask

    task automatic test_idle_ready();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'hFFFF;
        step();
        checks++;
        if ({wb_valid, stall, bus.mem_req} !== 3'b000)
            $display("FAIL idle_ready_ignored: got v=%b stall=%b req=%b expected 0 0 0",
                     wb_valid, stall, bus.mem_req);
        else passed++;
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_load();
        int stall_cycles = 0;
        issue(2'b10, 64'h0, 8'h20, 4'd5);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (stall && bus.mem_req && bus.mem_addr == 8'h20 && !bus.mem_we && !wb_valid)
                stall_cycles++;
            bus.mem_ready = (i == 2);
            bus.mem_rdata = (i == 2) ? 64'hDEAD : 64'h1111;
            step();
        end
        bus.mem_ready = 1'b0;
        checks++;
        if (stall_cycles !== 3)
            $display("FAIL load_busy_cycles: got %0d expected 3", stall_cycles);
        else passed++;
        checks++;
        if ({wb_valid, wb_en, wb_reg, wb_value, stall, bus.mem_req} !==
            {1'b1, 1'b1, 4'd5, 64'hDEAD, 1'b0, 1'b0})
            $display("FAIL load_wb: got v=%b en=%b reg=%h val=%h stall=%b req=%b expected 1 1 5 dead 0 0",
                     wb_valid, wb_en, wb_reg, wb_value, stall, bus.mem_req);
        else passed++;
        step();
        checks++;
        if (wb_valid !== 1'b0) $display("FAIL load_wb_pulse: got %b expected 0", wb_valid);
        else passed++;
    endtask

    task automatic test_store();
        issue(2'b11, 64'h77, 8'h08, 4'd2);
        step();
        in_valid = 1'b0;
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, wb_valid} !==
            {1'b1, 1'b1, 8'h08, 64'h77, 1'b0})
            $display("FAIL store_bus: got req=%b we=%b addr=%h wdata=%h v=%b expected 1 1 08 77 0",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, wb_valid);
        else passed++;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        checks++;
        if ({wb_valid, wb_en, wb_reg, stall} !== {1'b1, 1'b0, 4'd2, 1'b0})
            $display("FAIL store_wb: got v=%b en=%b reg=%h stall=%b expected 1 0 2 0",
                     wb_valid, wb_en, wb_reg, stall);
        else passed++;
    endtask

    task automatic test_back_to_back();
        issue(2'b10, 64'h0, 8'h30, 4'd1);
        step();
        issue(2'b01, 64'hAB, 8'h00, 4'd9);
        step();
        checks++;
        if ({wb_valid, stall} !== 2'b01)
            $display("FAIL b2b_ignored_in_busy: got v=%b stall=%b expected 0 1", wb_valid, stall);
        else passed++;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'h1234;
        step();
        bus.mem_ready = 1'b0;
        checks++;
        if ({wb_valid, wb_en, wb_reg, wb_value, stall} !== {1'b1, 1'b1, 4'd1, 64'h1234, 1'b0})
            $display("FAIL b2b_load_wb: got v=%b en=%b reg=%h val=%h stall=%b expected 1 1 1 1234 0",
                     wb_valid, wb_en, wb_reg, wb_value, stall);
        else passed++;
        step();
        in_valid = 1'b0;
        checks++;
        if ({wb_valid, wb_en, wb_reg, wb_value} !== {1'b1, 1'b1, 4'd9, 64'hAB})
            $display("FAIL b2b_alu_wb: got v=%b en=%b reg=%h val=%h expected 1 1 9 ab",
                     wb_valid, wb_en, wb_reg, wb_value);
        else passed++;
        step();
        checks++;
        if (wb_valid !== 1'b0) $display("FAIL b2b_single_pulse: got %b expected 0", wb_valid);
        else passed++;
    endtask

    task automatic test_ready_at_limit();
        issue(2'b10, 64'h0, 8'h60, 4'd7);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 14; i++) step();
        checks++;
        if ({stall, wb_valid} !== 2'b10)
            $display("FAIL limit_still_busy: got stall=%b v=%b expected 1 0", stall, wb_valid);
        else passed++;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'hBEEF;
        step();
        bus.mem_ready = 1'b0;
        checks++;
        if ({wb_valid, wb_en, wb_value, mem_err} !== {1'b1, 1'b1, 64'hBEEF, 1'b0})
            $display("FAIL limit_completion_wins: got v=%b en=%b val=%h err=%b expected 1 1 beef 0",
                     wb_valid, wb_en, wb_value, mem_err);
        else passed++;
    endtask

    task automatic test_reset_in_busy();
        logic [145:0] got;
        issue(2'b10, 64'h0, 8'h40, 4'd4);
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        got = {stall, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
               wb_valid, wb_en, wb_reg, wb_value, mem_err};
        checks++;
        if (got !== '0) $display("FAIL busy_reset_outputs: got %h expected 0", got);
        else passed++;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'h5555;
        step();
        bus.mem_ready = 1'b0;
        checks++;
        if ({wb_valid, stall, bus.mem_req} !== 3'b000)
            $display("FAIL busy_reset_no_wb: got v=%b stall=%b req=%b expected 0 0 0",
                     wb_valid, stall, bus.mem_req);
        else passed++;
    endtask

    task automatic test_timeout();
        int busy = 0;
        issue(2'b10, 64'h0, 8'h50, 4'd6);
        step();
        in_valid = 1'b0;
        while (stall && busy < 40) begin
            busy++;
            step();
        end
        checks++;
        if (busy !== 15) $display("FAIL timeout_busy_cycles: got %0d expected 15", busy);
        else passed++;
        checks++;
        if ({wb_valid, wb_en, mem_err, stall} !== 4'b1010)
            $display("FAIL timeout_abort: got v=%b en=%b err=%b stall=%b expected 1 0 1 0",
                     wb_valid, wb_en, mem_err, stall);
        else passed++;
        issue(2'b01, 64'h11, 8'h00, 4'd2);
        step();
        in_valid = 1'b0;
        checks++;
        if ({wb_valid, wb_en, wb_value, mem_err} !== {1'b1, 1'b1, 64'h11, 1'b1})
            $display("FAIL err_sticky: got v=%b en=%b val=%h err=%b expected 1 1 11 1",
                     wb_valid, wb_en, wb_value, mem_err);
        else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (mem_err !== 1'b0) $display("FAIL err_cleared_by_reset: got %b expected 0", mem_err);
        else passed++;
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        ctrl          = 2'b00;
        value_in      = '0;
        address_in    = '0;
        reg_in        = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;

        test_reset();
        test_alu();
        test_idle_ready();
        test_load();
        test_store();
        test_back_to_back();
        test_ready_at_limit();
        test_reset_in_busy();
        test_timeout();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have port clk  in  1  sole clock, rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port in_valid  in  1  execute-stage result present.
REQ-004 SHALL have port control_signals_in  in  2  00 bubble, 01 ALU writeback, 10 load, 11 store.
REQ-005 SHALL have port value_in  in  64  ALU result, or store data.
REQ-006 SHALL have port address_in  in  8  data-memory address.
REQ-007 SHALL have port reg_to_be_written_in  in  4  destination register.
REQ-008 SHALL have port stall  out  1  upstream holds its outputs while high.
REQ-009 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 8, mem_wdata out 64; mem_ready in 1, mem_rdata in 64.
REQ-010 SHALL have ports wb_valid out 1, wb_en out 1, wb_reg out 4, wb_value out 64, mem_err out 1.

Function
REQ-011 SHALL implement the FSM states IDLE and BUSY, where stall = (state==BUSY), driven from a register.
REQ-012 SHALL accept an instruction only when in_valid=1 and state==IDLE; inputs presented in BUSY SHALL be ignored.
REQ-013 An accepted 00 or 01 instruction SHALL drive wb_valid=1 at the next edge; wb_en=1 only for 01; wb_reg and wb_value are taken from the inputs.
REQ-014 An accepted 10 or 11 instruction SHALL latch addr, data and we (1 for store), enter BUSY at the next edge, and produce no wb output that cycle.
REQ-015 In BUSY, mem_req SHALL be 1 and mem_addr, mem_we, mem_wdata SHALL be stable until completion; in IDLE, mem_req SHALL be 0.
REQ-016 In BUSY, mem_ready=1 completes the access: next edge state becomes IDLE and wb_valid=1.
REQ-017 On completion of a load, the stage SHALL set wb_en=1 and wb_value=mem_rdata sampled on the completion edge.
REQ-018 On completion of a store, the stage SHALL set wb_en=0.
REQ-019 Minimum mem-op timing SHALL be: accept at cycle t, mem_req at t+1, wb at t+2 if mem_ready is asserted at t+1.
REQ-020 wb_valid SHALL be high for exactly one cycle per completed instruction and 0 otherwise; wb_reg and wb_value hold their values when wb_valid=0.
REQ-021 A 4-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle with mem_ready=0.
REQ-022 When the wait counter reaches TIMEOUT=15 with mem_ready=0, the stage SHALL abort: next edge IDLE, wb_valid=1, wb_en=0, mem_err=1.
REQ-023 If mem_ready=1 in the same cycle the counter reaches 15, completion SHALL win and there SHALL be no error.
REQ-024 mem_err SHALL be sticky until rst.
REQ-025 mem_ready asserted in IDLE SHALL be ignored.
REQ-026 in_valid=0 in IDLE SHALL yield wb_valid=0 at the next edge.

Reset
REQ-027 When rst=1 at an edge, the stage SHALL set state=IDLE, stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_en=0, wb_reg=0, wb_value=0, counter=0, mem_err=0.
REQ-028 Reset SHALL take priority over all inputs; a reset during BUSY SHALL drop the request with no wb output.

Structure
REQ-029 Package mem_stage_pkg SHALL hold the control encodings (CTRL_NOP, CTRL_ALU, CTRL_LOAD, CTRL_STORE), the state enum, and TIMEOUT=15.
REQ-030 The wait counter SHALL be a sub-module, mem_timeout_counter, with inputs clear and enable and output expired.
REQ-031 The rest of the stage SHALL be a single FSM plus output registers in mem_access_stage.

Verification
REQ-032 ALU op, in_valid=1, ctrl=01, value=64'h5, reg=3 -> next cycle wb_valid=1, wb_en=1, wb_reg=3, wb_value=5, stall=0.
REQ-033 Load, ctrl=10, addr=8'h20, mem_ready at 3rd BUSY cycle with rdata=64'hDEAD -> mem_req with addr 20 for 3 cycles, stall high for 3 cycles, then wb_en=1, wb_value=DEAD.
REQ-034 Store, ctrl=11, addr=8'h08, value=64'h77, mem_ready on the first BUSY cycle -> mem_we=1, mem_wdata=77, then wb_valid=1, wb_en=0, total 2-cycle latency.
REQ-035 Load with mem_ready never asserted -> after 15 BUSY cycles: IDLE, wb_valid=1, wb_en=0, mem_err=1, which stays high across a later successful ALU op.
REQ-036 rst asserted in the 2nd BUSY cycle of a load -> next cycle all outputs 0; a subsequent mem_ready produces no wb output.
REQ-037 Back-to-back load then ALU op with the ALU inputs held under stall -> the ALU op is accepted only in the first IDLE cycle after load completion, with wb pulses in consecutive cycles.
